// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse sequencer: NCH timed pulses, a sync strobe and a block window,
// repeating at a programmable period. Shadow timing registers are applied at period boundaries.
module multi_pulse_gen #(
    parameter int NCH = 2,
    parameter int CW  = 32,
    parameter int AW  = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [CW-1:0]  cfg_data,
    input  logic           start,
    input  logic           stop,
    output logic [NCH-1:0] pulse,
    output logic           sync,
    output logic           block,
    output logic           busy,
    output logic           done
);

    // IDLE: waiting for start; RUN: sequencing periods
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_sh_period, r_sh_sync_w, r_sh_guard, r_sh_repeat;
    logic [CW-1:0] r_sh_delay [NCH];
    logic [CW-1:0] r_sh_width [NCH];

    logic [CW-1:0] r_period, r_sync_w, r_guard, r_repeat, r_end;
    logic [CW-1:0] r_delay [NCH];
    logic [CW-1:0] r_width [NCH];

    logic [CW-1:0] r_cnt, r_idx;
    logic          r_stop_pend;

    logic [NCH-1:0] r_pulse;
    logic           r_sync, r_block, r_done;

    logic [CW-1:0]  w_sh_period;
    logic [CW:0]    w_sh_clip [NCH];
    logic [CW:0]    w_sh_end;
    logic [NCH-1:0] w_pulse;
    logic           w_run, w_per_end, w_finish, w_start_load, w_reload, w_load;

    assign w_run        = (r_state == S_RUN);
    assign w_per_end    = w_run && (r_cnt == r_period - CW'(1));
    assign w_finish     = r_stop_pend || ((r_repeat != '0) && (r_idx == r_repeat - CW'(1)));
    assign w_start_load = (r_state == S_IDLE) && start;
    assign w_reload     = w_per_end && !w_finish;
    assign w_load       = w_start_load || w_reload;

    assign w_sh_period  = (r_sh_period < CW'(2)) ? CW'(2) : r_sh_period;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW:0] w_sh_sum;
        logic [CW:0] w_act_sum;
        assign w_sh_sum     = {1'b0, r_sh_delay[g]} + {1'b0, r_sh_width[g]};
        assign w_sh_clip[g] = (w_sh_sum > {1'b0, w_sh_period}) ? {1'b0, w_sh_period} : w_sh_sum;
        assign w_act_sum    = {1'b0, r_delay[g]} + {1'b0, r_width[g]};
        assign w_pulse[g]   = (r_cnt >= r_delay[g]) && ({1'b0, r_cnt} < w_act_sum);
    end

    // END is taken from the shadow set at the load edge, so it is valid from cnt=0 onward
    always_comb begin
        w_sh_end = '0;
        for (int k = 0; k < NCH; k++) begin
            if ((r_sh_width[k] != '0) && (w_sh_clip[k] > w_sh_end)) begin
                w_sh_end = w_sh_clip[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_per_end && w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_period <= '0;
            r_sh_sync_w <= '0;
            r_sh_guard  <= '0;
            r_sh_repeat <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_sh_delay[k] <= '0;
                r_sh_width[k] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_addr == AW'(0)) r_sh_period <= cfg_data;
            if (cfg_addr == AW'(1)) r_sh_sync_w <= cfg_data;
            if (cfg_addr == AW'(2)) r_sh_guard  <= cfg_data;
            if (cfg_addr == AW'(3)) r_sh_repeat <= cfg_data;
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr == AW'(4 + 2 * k)) r_sh_delay[k] <= cfg_data;
                if (cfg_addr == AW'(5 + 2 * k)) r_sh_width[k] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= '0;
            r_sync_w <= '0;
            r_guard  <= '0;
            r_repeat <= '0;
            r_end    <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_delay[k] <= '0;
                r_width[k] <= '0;
            end
        end else if (w_load) begin
            r_period <= w_sh_period;
            r_sync_w <= r_sh_sync_w;
            r_guard  <= r_sh_guard;
            r_repeat <= r_sh_repeat;
            r_end    <= w_sh_end[CW-1:0];
            for (int k = 0; k < NCH; k++) begin
                r_delay[k] <= r_sh_delay[k];
                r_width[k] <= r_sh_width[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_pend <= 1'b0;
        end else if (w_start_load) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_pend <= 1'b0;
        end else if (w_run) begin
            if (w_per_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + CW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (stop) r_stop_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse <= '0;
            r_sync  <= 1'b0;
            r_block <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pulse <= w_run ? w_pulse : '0;
            r_sync  <= w_run && (r_cnt < r_sync_w);
            r_block <= w_run && ({2'b0, r_cnt} < ({2'b0, r_end} + {2'b0, r_guard}));
            r_done  <= w_per_end && w_finish;
        end
    end

    assign pulse = r_pulse;
    assign sync  = r_sync;
    assign block = r_block;
    assign done  = r_done;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen; cycle k is the k-th clock after the edge that samples start.
module tb_multi_pulse_gen;

    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam int AW  = 6;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_we = 1'b0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [CW-1:0]  cfg_data = '0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [NCH-1:0] pulse;
    logic           sync, block, busy, done;

    int n_chk  = 0;
    int n_pass = 0;
    int k_cyc  = 0;

    always #5 clk = ~clk;

    multi_pulse_gen #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .stop     (stop),
        .pulse    (pulse),
        .sync     (sync),
        .block    (block),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, k_cyc, obs, exp);
    endtask

    function automatic logic win(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic cfg_wr(input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = CW'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    // PERIOD=100, three repeats, two channels
    task automatic t_basic();
        int m;
        logic inrun;
        cfg_wr(0, 100); cfg_wr(1, 3); cfg_wr(2, 4); cfg_wr(3, 3);
        cfg_wr(4, 10);  cfg_wr(5, 5); cfg_wr(6, 20); cfg_wr(7, 10);
        cfg_wr(8, 1);   cfg_wr(63, 7);
        kick();
        for (int k = 1; k <= 303; k++) begin
            @(negedge clk);
            start = 1'b0;
            k_cyc = k;
            inrun = win(k, 2, 301);
            m = inrun ? (k - 2) % 100 : 0;
            check("basic_busy",   busy,     win(k, 1, 300));
            check("basic_done",   done,     k == 301);
            check("basic_sync",   sync,     inrun && win(m, 0, 2));
            check("basic_pulse0", pulse[0], inrun && win(m, 10, 14));
            check("basic_pulse1", pulse[1], inrun && win(m, 20, 29));
            check("basic_block",  block,    inrun && win(m, 0, 33));
        end
    endtask

    // Pulse0 truncated at period end, channel 1 disabled, END clipped to PERIOD
    task automatic t_trunc();
        int m;
        logic inrun;
        cfg_wr(0, 50); cfg_wr(3, 2); cfg_wr(4, 45); cfg_wr(5, 20); cfg_wr(6, 5); cfg_wr(7, 0);
        kick();
        for (int k = 1; k <= 103; k++) begin
            @(negedge clk);
            start = 1'b0;
            k_cyc = k;
            inrun = win(k, 2, 101);
            m = inrun ? (k - 2) % 50 : 0;
            check("trunc_busy",   busy,     win(k, 1, 100));
            check("trunc_done",   done,     k == 101);
            check("trunc_pulse0", pulse[0], inrun && win(m, 45, 49));
            check("trunc_pulse1", pulse[1], 1'b0);
            check("trunc_block",  block,    inrun);
        end
    endtask

    // Shadow writes mid-period and on the reload edge
    task automatic t_live();
        cfg_wr(0, 100); cfg_wr(3, 0); cfg_wr(4, 10); cfg_wr(5, 5);
        kick();
        for (int k = 1; k <= 403; k++) begin
            @(negedge clk);
            start  = 1'b0;
            stop   = 1'b0;
            cfg_we = 1'b0;
            k_cyc  = k;
            check("live_pulse0", pulse[0],
                  win(k, 12, 16) || win(k, 132, 136) || win(k, 232, 236) || win(k, 352, 356));
            check("live_busy", busy, win(k, 1, 400));
            check("live_done", done, k == 401);
            if (k == 41) begin
                cfg_we = 1'b1; cfg_addr = AW'(4); cfg_data = CW'(30);
            end
            if (k == 200) begin
                cfg_we = 1'b1; cfg_addr = AW'(4); cfg_data = CW'(50);
            end
            if (k == 350) stop = 1'b1;
        end
    endtask

    // Graceful stop, start ignored in RUN, restart on the cycle after done
    task automatic t_stop();
        cfg_wr(0, 20); cfg_wr(4, 2); cfg_wr(5, 3);
        kick();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            k_cyc = k;
            check("stop_busy",   busy,     win(k, 1, 40) || win(k, 42, 61));
            check("stop_done",   done,     (k == 41) || (k == 62));
            check("stop_pulse0", pulse[0], win(k, 4, 6) || win(k, 24, 26) || win(k, 45, 47));
            check("stop_sync",   sync,     win(k, 2, 4) || win(k, 22, 24) || win(k, 43, 45));
            check("stop_block",  block,    win(k, 2, 10) || win(k, 22, 30) || win(k, 43, 51));
            if (k == 10 || k == 41) start = 1'b1;
            if (k == 31 || k == 50) stop = 1'b1;
        end
    endtask

    // PERIOD=0 clamps to 2; then async reset mid-pulse and an all-zero-timing run
    task automatic t_clamp_reset();
        cfg_wr(0, 0); cfg_wr(1, 1); cfg_wr(2, 0); cfg_wr(3, 3); cfg_wr(4, 1); cfg_wr(5, 1);
        kick();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            k_cyc = k;
            check("clamp_busy",   busy,     win(k, 1, 6));
            check("clamp_done",   done,     k == 7);
            check("clamp_pulse0", pulse[0], (k == 3) || (k == 5) || (k == 7));
            check("clamp_sync",   sync,     (k == 2) || (k == 4) || (k == 6));
            check("clamp_block",  block,    win(k, 2, 7));
        end

        cfg_wr(0, 100); cfg_wr(1, 3); cfg_wr(2, 4); cfg_wr(3, 0); cfg_wr(4, 10); cfg_wr(5, 5);
        kick();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            k_cyc = k;
        end
        check("pre_rst_pulse0", pulse[0], 1'b1);
        check("pre_rst_block",  block,    1'b1);
        check("pre_rst_busy",   busy,     1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_pulse0", pulse[0], 1'b0);
        check("rst_sync",   sync,     1'b0);
        check("rst_block",  block,    1'b0);
        check("rst_busy",   busy,     1'b0);
        check("rst_done",   done,     1'b0);
        @(negedge clk);
        reset = 1'b0;

        kick();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            k_cyc = k;
            check("zero_busy",  busy,  win(k, 1, 6));
            check("zero_done",  done,  k == 7);
            check("zero_pulse", pulse, 2'b00);
            check("zero_sync",  sync,  1'b0);
            check("zero_block", block, 1'b0);
            if (k == 5) stop = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_pulse", pulse, 2'b00);
        check("reset_sync",  sync,  1'b0);
        check("reset_block", block, 1'b0);
        check("reset_busy",  busy,  1'b0);
        check("reset_done",  done,  1'b0);
        reset = 1'b0;

        t_basic();
        t_trunc();
        t_live();
        t_stop();
        t_clamp_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
